// File: rtl/button_pkg.sv
// Shared definitions for the push-button peripheral: channel FSM states and
// the debounce-length helper.
package button_pkg;

    localparam int unsigned BTN_MAX = 8;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_COUNT  = 1'b1
    } db_state_e;

    function automatic int unsigned db_cycles(input int unsigned clk_hz,
                                              input int unsigned debounce_ms);
        return clk_hz / 1000 * debounce_ms;
    endfunction

endpackage

// File: rtl/button_input_debounce_channel.sv
// One button: 2-flop synchroniser, polarity normalisation, debounce counter
// FSM and a registered rising-edge press pulse aligned with the level rise.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned    CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          pressed;
    db_state_e     fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    assign pressed = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (fsm_q)
            DB_STABLE: begin
                cnt_d = '0;
                if (pressed != level_q) begin
                    fsm_d = DB_COUNT;
                    cnt_d = CW'(1);
                end
            end
            DB_COUNT: begin
                if (pressed == level_q) begin
                    fsm_d = DB_STABLE;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = pressed;
                    fsm_d   = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                fsm_d = DB_STABLE;
                cnt_d = '0;
            end
        endcase
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
            fsm_q   <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/button_input.sv
// Debounced push-button peripheral: per-button channels, sticky press flags
// cleared by software, and a one-cycle press interrupt.
module button_input
    import button_pkg::*;
#(
    parameter int unsigned NUM_BTNS    = 4,
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [7:0]          state,
    output logic [7:0]          events,
    input  logic                clear_enable,
    input  logic [7:0]          clear_mask,
    input  logic                interrupt_enable,
    output logic                interrupt
);

    localparam int unsigned        DB_CYCLES  = db_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam logic [BTN_MAX-1:0] VALID_MASK = BTN_MAX'((1 << NUM_BTNS) - 1);

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press;
    logic [BTN_MAX-1:0]  press_ext;
    logic [BTN_MAX-1:0]  events_q, events_d;
    logic                interrupt_q, interrupt_d;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[i]),
            .level   (level[i]),
            .press   (press[i])
        );
    end

    assign press_ext = BTN_MAX'(press);

    // Set wins over clear; unimplemented bits are forced to zero.
    always_comb begin
        events_d    = ((events_q & ~({BTN_MAX{clear_enable}} & clear_mask)) | press_ext)
                      & VALID_MASK;
        interrupt_d = interrupt_enable & (|press);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            events_q    <= '0;
            interrupt_q <= 1'b0;
        end else begin
            events_q    <= events_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign state     = BTN_MAX'(level);
    assign events    = events_q;
    assign interrupt = interrupt_q;

endmodule
